mem_responder: RTL and testbench

- Memory-side responder for the ktc32 multicycle core.
- Services single-word read/write requests issued by the controller/datapath, with address muxed by iord and write strobed by memwrite.
- Provides a req/ready handshake with a configurable number of wait states, so the core's FSM can stall on slow memory.
- Holds unified instruction/data storage. Flags misaligned and out-of-range accesses with an error response.

---
 rtl/ktc32_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_array.sv | 39 +++
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ktc32_pkg.sv
// Shared ktc32 memory-side types: word width, responder FSM states and
// the word-index width helper.
package ktc32_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the ktc32 core and its memory responder.
interface mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read; the read register
// can be loaded with zero instead of array contents.
module mem_array
  import ktc32_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read register is reset separately so the storage itself stays reset-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= clr_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ktc32 memory responder: accepts one word request in IDLE, waits
// WAIT_CYCLES, then pulses ready with error/read data for one cycle.
module mem_responder
  import ktc32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = WORD_W,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  accept;
  logic                  enter_resp;
  logic                  req_err;
  logic                  ram_en;
  logic [WORD_W-1:0]     ram_rdata;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign we_d    = accept ? bus.we    : we_q;
  assign addr_d  = accept ? bus.addr  : addr_q;
  assign wdata_d = accept ? bus.wdata : wdata_q;

  // The RAM op fires on the edge entering RESP. It uses the _d request view
  // so a zero-wait access sees the request being latched on that same edge.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign req_err    = addr_err(addr_d);
  assign ram_en     = enter_resp && !(we_d && req_err);

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .en_i    (ram_en),
    .we_i    (we_d),
    .clr_i   (req_err),
    .idx_i   (addr_d[IDX_W+1:2]),
    .wdata_i (wdata_d),
    .rdata_o (ram_rdata)
  );

  assign bus.ready = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && addr_err(addr_q);
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = ram_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  mem_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mem_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      ifb.req = r; ifb.we = w; ifb.addr = a; ifb.wdata = d;
    end else begin
      ifa.req = r; ifa.we = w; ifa.addr = a; ifa.wdata = d;
    end
  endtask

  // One access: drive the request, then scramble inputs while busy and
  // record latency (negedges after the acceptance edge) and busy cycles.
  task automatic xfer(input bit sel, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int lat, output int nb);
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    lat = 0; nb = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, ~w, ~a, ~d);
      if (sel ? ifb.busy : ifa.busy) nb++;
      if (sel ? ifb.ready : ifa.ready) begin
        lat = k;
        rd  = sel ? ifb.rdata : ifa.rdata;
        er  = sel ? ifb.err : ifa.err;
      end
    end
  endtask

  logic [31:0] hold_addr [10] = '{32'h0, 32'h8, 32'h8, 32'h0, 32'h0,
                                  32'h8, 32'h8, 32'h0, 32'h0, 32'h8};
  logic [31:0] hold_exp [11]  = '{32'h0, 32'hAAAA0000, 32'h0, 32'hBBBB0008,
                                  32'h0, 32'hAAAA0000, 32'h0, 32'hBBBB0008,
                                  32'h0, 32'hAAAA0000, 32'h0};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nb;
    int          seen;

    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    chk("rst_a_ready", 32'(ifa.ready), 32'd0);
    chk("rst_a_err",   32'(ifa.err),   32'd0);
    chk("rst_a_busy",  32'(ifa.busy),  32'd0);
    chk("rst_a_rdata", ifa.rdata,      32'h0);
    chk("rst_b_busy",  32'(ifb.busy),  32'd0);
    chk("rst_b_rdata", ifb.rdata,      32'h0);
    reset = 1'b0;

    // Reset in the middle of a write discards it.
    xfer(1'b0, 1'b1, 32'h10, 32'h11111111, rd, er, lat, nb);
    chk("pre_wr_lat", 32'(lat), 32'd3);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    chk("pre_rd_data", rd, 32'h11111111);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mid_busy", 32'(ifa.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(ifa.busy),  32'd0);
    chk("mid_rst_rdata", ifa.rdata,      32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ifa.ready) seen++;
    end
    chk("mid_no_ready", 32'(seen), 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, nb);
    chk("mid_rd_old", rd, 32'h11111111);

    // Write then read with two wait states.
    xfer(1'b0, 1'b1, 32'h4, 32'h12345678, rd, er, lat, nb);
    chk("wr_lat",  32'(lat), 32'd3);
    chk("wr_busy", 32'(nb),  32'd3);
    chk("wr_err",  32'(er),  32'd0);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, rd, er, lat, nb);
    chk("rd_lat",  32'(lat), 32'd3);
    chk("rd_busy", 32'(nb),  32'd3);
    chk("rd_err",  32'(er),  32'd0);
    chk("rd_data", rd,       32'h12345678);
    @(negedge clk);
    chk("rd_hold", ifa.rdata, 32'h12345678);

    // Misaligned write is rejected and leaves memory and rdata alone.
    xfer(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, rd, er, lat, nb);
    chk("mis_lat", 32'(lat), 32'd3);
    chk("mis_err", 32'(er),  32'd1);
    chk("mis_rdata_hold", rd, 32'h12345678);
    @(negedge clk);
    chk("mis_err_clear", 32'(ifa.err), 32'd0);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, rd, er, lat, nb);
    chk("mis_rd_data", rd, 32'h12345678);

    // Range boundary.
    xfer(1'b0, 1'b0, 32'h1000, 32'h0, rd, er, lat, nb);
    chk("oor_err",  32'(er), 32'd1);
    chk("oor_data", rd,      32'h0);
    xfer(1'b0, 1'b1, 32'hFFC, 32'hA5A5A5A5, rd, er, lat, nb);
    chk("top_wr_err", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'hFFC, 32'h0, rd, er, lat, nb);
    chk("top_rd_err",  32'(er), 32'd0);
    chk("top_rd_data", rd,      32'hA5A5A5A5);

    // Zero wait states: single access, then req held with changing address.
    xfer(1'b1, 1'b1, 32'h0, 32'hAAAA0000, rd, er, lat, nb);
    chk("b_wr_lat",  32'(lat), 32'd1);
    chk("b_wr_busy", 32'(nb),  32'd1);
    xfer(1'b1, 1'b1, 32'h8, 32'hBBBB0008, rd, er, lat, nb);
    chk("b_wr2_err", 32'(er), 32'd0);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("hold_ready%0d", i), 32'(ifb.ready), 32'(i % 2));
        if (i % 2 == 1) chk($sformatf("hold_rdata%0d", i), ifb.rdata, hold_exp[i]);
      end
      if (i < 10) drive(1'b1, 1'b1, 1'b0, hold_addr[i], 32'(i));
      else        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
